iq_unpack_stream: RTL and testbench

//  Parametrised successor to the single-pair IQ reader. Pulls packed words from a

---
 rtl/iq_unpack_stream_pkg.sv | 28 ++
 rtl/iq_unpack_stream_pair_select.sv | 38 +++
 rtl/iq_unpack_stream.sv | 144 ++++++++++++++
 tb/tb_iq_unpack_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_unpack_stream_pkg.sv
// Shared types and sample arithmetic for the IQ unpack front end.
// Sign-extension and quantisation are done at a fixed maximum width, and callers truncate.
package iq_pkg;

    typedef enum logic {EMPTY, HOLD} iq_unpack_state_t;

    localparam int unsigned DEFAULT_SAMPLE_WIDTH = 16;
    localparam int unsigned DEFAULT_QUANTIZE     = 10;
    localparam int unsigned QUANT_MAX_WIDTH      = 64;
    localparam int unsigned QUANT_IDX_WIDTH      = $clog2(QUANT_MAX_WIDTH);

    // Sign-extend the low sample_width bits of sample, then shift left by shift.
    function automatic logic [QUANT_MAX_WIDTH-1:0] iq_quantize(
        input logic [QUANT_MAX_WIDTH-1:0] sample,
        input int unsigned                sample_width,
        input int unsigned                shift
    );
        logic [QUANT_MAX_WIDTH-1:0] ext;
        ext = sample;
        for (int unsigned b = 0; b < QUANT_MAX_WIDTH; b++) begin
            if (b >= sample_width) begin
                ext[QUANT_IDX_WIDTH'(b)] = sample[QUANT_IDX_WIDTH'(sample_width - 1)];
            end
        end
        return ext << shift;
    endfunction

endpackage

// File: rtl/iq_unpack_stream_pair_select.sv
// Picks pair idx out of the held packed word and splits it into raw I and Q samples.
module iq_pair_select #(
    parameter int unsigned IN_WIDTH     = 32,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned IDX_WIDTH    = 1
) (
    input  logic [IN_WIDTH-1:0]     word_q,
    input  logic [IDX_WIDTH-1:0]    idx,
    input  logic                    swap_q,
    output logic [SAMPLE_WIDTH-1:0] raw_i,
    output logic [SAMPLE_WIDTH-1:0] raw_q
);

    localparam int unsigned PAIR_WIDTH = 2 * SAMPLE_WIDTH;
    localparam int unsigned PAIRS      = IN_WIDTH / PAIR_WIDTH;

    logic [PAIR_WIDTH-1:0] w_pair;

    always_comb begin
        w_pair = '0;
        for (int unsigned k = 0; k < PAIRS; k++) begin
            if (idx == IDX_WIDTH'(k)) begin
                w_pair = word_q[PAIR_WIDTH*k +: PAIR_WIDTH];
            end
        end
    end

    always_comb begin
        if (swap_q) begin
            raw_i = w_pair[PAIR_WIDTH-1:SAMPLE_WIDTH];
            raw_q = w_pair[SAMPLE_WIDTH-1:0];
        end else begin
            raw_i = w_pair[SAMPLE_WIDTH-1:0];
            raw_q = w_pair[PAIR_WIDTH-1:SAMPLE_WIDTH];
        end
    end

endmodule

// File: rtl/iq_unpack_stream.sv
// Unpacks multi-pair words from an FWFT FIFO into one quantised I/Q pair per cycle.
// On the last pair of a word, the next word is loaded in the same cycle, so there is no bubble.
module iq_unpack_stream
    import iq_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 32,
    parameter int unsigned SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned QUANTIZE_WIDTH = DEFAULT_QUANTIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_empty,
    input  logic [IN_WIDTH-1:0]   in_dout,
    output logic                  in_rd_en,
    input  logic                  swap_iq,
    input  logic                  flush,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic [31:0]           pair_count
);

    localparam int unsigned PAIRS     = IN_WIDTH / (2 * SAMPLE_WIDTH);
    localparam int unsigned IDX_WIDTH = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    generate
        if (SAMPLE_WIDTH + QUANTIZE_WIDTH > DATA_WIDTH) begin : g_bad_data_width
            $error("iq_unpack_stream: SAMPLE_WIDTH+QUANTIZE_WIDTH exceeds DATA_WIDTH");
        end
        if ((IN_WIDTH % (2 * SAMPLE_WIDTH)) != 0 || PAIRS < 1) begin : g_bad_in_width
            $error("iq_unpack_stream: IN_WIDTH must be a nonzero multiple of 2*SAMPLE_WIDTH");
        end
        if (DATA_WIDTH > QUANT_MAX_WIDTH) begin : g_bad_max_width
            $error("iq_unpack_stream: DATA_WIDTH exceeds quantiser width");
        end
    endgenerate

    iq_unpack_state_t      r_state;
    iq_unpack_state_t      w_state_nxt;
    logic [IN_WIDTH-1:0]   r_word;
    logic [IN_WIDTH-1:0]   w_word_nxt;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  w_idx_nxt;
    logic                  r_swap;
    logic                  w_swap_nxt;
    logic [31:0]           r_pair_count;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_last;
    logic [SAMPLE_WIDTH-1:0] w_raw_i;
    logic [SAMPLE_WIDTH-1:0] w_raw_q;

    iq_pair_select #(
        .IN_WIDTH     (IN_WIDTH),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .IDX_WIDTH    (IDX_WIDTH)
    ) u_pair_select (
        .word_q (r_word),
        .idx    (r_idx),
        .swap_q (r_swap),
        .raw_i  (w_raw_i),
        .raw_q  (w_raw_q)
    );

    assign w_last = (r_idx == IDX_WIDTH'(PAIRS - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= EMPTY;
            r_word       <= '0;
            r_idx        <= '0;
            r_swap       <= 1'b0;
            r_pair_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
            r_swap  <= w_swap_nxt;
            if (out_wr_en) begin
                r_pair_count <= r_pair_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        w_swap_nxt  = r_swap;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (!in_empty) begin
                        w_rd        = 1'b1;
                        w_word_nxt  = in_dout;
                        w_idx_nxt   = '0;
                        w_swap_nxt  = swap_iq;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (!out_full) begin
                        w_wr = 1'b1;
                        if (!w_last) begin
                            w_idx_nxt = r_idx + IDX_WIDTH'(1);
                        end else if (!in_empty) begin
                            // Reload in the write cycle of the last pair to keep one pair per cycle.
                            w_rd       = 1'b1;
                            w_word_nxt = in_dout;
                            w_idx_nxt  = '0;
                            w_swap_nxt = swap_iq;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Handshakes are gated by reset so that no FIFO pop or push happens while reset is held.
    assign in_rd_en  = w_rd & reset;
    assign out_wr_en = w_wr & reset;

    always_comb begin
        i_out = '0;
        q_out = '0;
        if (r_state == HOLD) begin
            i_out = DATA_WIDTH'(iq_quantize(QUANT_MAX_WIDTH'(w_raw_i), SAMPLE_WIDTH, QUANTIZE_WIDTH));
            q_out = DATA_WIDTH'(iq_quantize(QUANT_MAX_WIDTH'(w_raw_q), SAMPLE_WIDTH, QUANTIZE_WIDTH));
        end
    end

    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_iq_unpack_stream.sv
// Directed bench: dut A uses the default widths (one pair per word), dut B uses 64-bit words (two pairs).
module tb_iq_unpack_stream;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // dut A: defaults
    logic        a_reset, a_empty, a_rd, a_swap, a_flush, a_full, a_wr;
    logic [31:0] a_dout, a_i, a_q, a_cnt;
    logic [31:0] a_mem [0:31];
    int          a_wp = 0;
    int          a_rp = 0;

    // dut B: two pairs per word
    logic        b_reset, b_empty, b_rd, b_swap, b_flush, b_full, b_wr;
    logic [63:0] b_dout;
    logic [31:0] b_i, b_q, b_cnt;
    logic [63:0] b_mem [0:31];
    int          b_wp = 0;
    int          b_rp = 0;

    assign a_empty = (a_wp == a_rp);
    assign a_dout  = a_mem[a_rp[4:0]];
    assign b_empty = (b_wp == b_rp);
    assign b_dout  = b_mem[b_rp[4:0]];

    always @(posedge clock) if (a_rd) a_rp <= a_rp + 1;
    always @(posedge clock) if (b_rd) b_rp <= b_rp + 1;

    iq_unpack_stream dut_a (
        .clock(clock), .reset(a_reset), .in_empty(a_empty), .in_dout(a_dout),
        .in_rd_en(a_rd), .swap_iq(a_swap), .flush(a_flush), .out_full(a_full),
        .out_wr_en(a_wr), .i_out(a_i), .q_out(a_q), .pair_count(a_cnt)
    );

    iq_unpack_stream #(.IN_WIDTH(64)) dut_b (
        .clock(clock), .reset(b_reset), .in_empty(b_empty), .in_dout(b_dout),
        .in_rd_en(b_rd), .swap_iq(b_swap), .flush(b_flush), .out_full(b_full),
        .out_wr_en(b_wr), .i_out(b_i), .q_out(b_q), .pair_count(b_cnt)
    );

    typedef struct {
        logic [31:0] word;
        logic        swap;
        logic [31:0] exp_i;
        logic [31:0] exp_q;
    } vec_t;

    vec_t      vecs [6];
    logic [63:0] t3w [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [31:0] w);
        a_mem[a_wp[4:0]] = w;
        a_wp = a_wp + 1;
    endtask

    task automatic push_b(input logic [63:0] w);
        b_mem[b_wp[4:0]] = w;
        b_wp = b_wp + 1;
    endtask

    function automatic logic [31:0] quant(input logic [15:0] s);
        logic [31:0] r;
        r = {{16{s[15]}}, s};
        return r << 10;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0003FFFF, 1'b0, 32'hFFFFFC00, 32'h00000C00};
        vecs[1] = '{32'h0003FFFF, 1'b1, 32'h00000C00, 32'hFFFFFC00};
        vecs[2] = '{32'h7FFF8000, 1'b0, 32'hFE000000, 32'h01FFFC00};
        vecs[3] = '{32'h00010001, 1'b1, 32'h00000400, 32'h00000400};
        vecs[4] = '{32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h80007FFF, 1'b1, 32'hFE000000, 32'h01FFFC00};
        t3w[0] = 64'h1234_8001_FFFF_0005;
        t3w[1] = 64'h0000_7FFF_8000_0001;
        t3w[2] = 64'hABCD_EF01_2345_6789;
        t3w[3] = 64'h0F0F_F0F0_0001_FFFE;

        a_reset = 1'b0; a_swap = 1'b0; a_flush = 1'b0; a_full = 1'b0;
        b_reset = 1'b0; b_swap = 1'b0; b_flush = 1'b0; b_full = 1'b0;
        tick(); tick();
        check("rst_a_rd", 32'(a_rd), 32'd0);
        check("rst_a_wr", 32'(a_wr), 32'd0);
        check("rst_a_i", a_i, 32'd0);
        check("rst_a_q", a_q, 32'd0);
        check("rst_a_cnt", a_cnt, 32'd0);
        check("rst_b_i", b_i, 32'd0);
        check("rst_b_cnt", b_cnt, 32'd0);
        a_reset = 1'b1; b_reset = 1'b1;
        tick();

        // Single-pair vectors: pop, write one cycle later, then idle.
        for (int v = 0; v < 6; v++) begin
            a_swap = vecs[v].swap;
            push_a(vecs[v].word);
            #1;
            check("vec_pop", 32'(a_rd), 32'd1);
            check("vec_nowr", 32'(a_wr), 32'd0);
            tick();
            check("vec_wr", 32'(a_wr), 32'd1);
            check("vec_i", a_i, vecs[v].exp_i);
            check("vec_q", a_q, vecs[v].exp_q);
            tick();
            check("vec_idle_wr", 32'(a_wr), 32'd0);
            check("vec_idle_i", a_i, 32'd0);
        end
        check("vec_cnt", a_cnt, 32'd6);

        // Reset mid-word: held word dropped, pending word popped right after release.
        a_swap = 1'b0; a_full = 1'b1;
        push_a(32'h0003FFFF);
        push_a(32'h00050002);
        #1;
        check("t6_pop", 32'(a_rd), 32'd1);
        tick();
        check("t6_held_wr", 32'(a_wr), 32'd0);
        check("t6_held_i", a_i, 32'hFFFFFC00);
        a_reset = 1'b0;
        #1;
        check("t6_rst_i", a_i, 32'd0);
        check("t6_rst_q", a_q, 32'd0);
        check("t6_rst_cnt", a_cnt, 32'd0);
        check("t6_rst_rd", 32'(a_rd), 32'd0);
        check("t6_rst_wr", 32'(a_wr), 32'd0);
        tick();
        a_reset = 1'b1; a_full = 1'b0;
        #1;
        check("t6_repop", 32'(a_rd), 32'd1);
        tick();
        check("t6_wr", 32'(a_wr), 32'd1);
        check("t6_i", a_i, 32'h00000800);
        check("t6_q", a_q, 32'h00001400);
        tick();
        check("t6_cnt", a_cnt, 32'd1);

        // T3: four preloaded words stream as eight back-to-back pairs.
        b_swap = 1'b0;
        for (int w = 0; w < 4; w++) push_b(t3w[w]);
        for (int c = 0; c < 9; c++) begin
            logic [63:0] wv;
            logic [31:0] pr;
            #1;
            check("t3_rd", 32'(b_rd), (c == 0 || c == 2 || c == 4 || c == 6) ? 32'd1 : 32'd0);
            check("t3_wr", 32'(b_wr), (c >= 1) ? 32'd1 : 32'd0);
            if (c >= 1) begin
                wv = t3w[(c - 1) / 2];
                pr = ((c - 1) % 2 == 1) ? wv[63:32] : wv[31:0];
                check("t3_i", b_i, quant(pr[15:0]));
                check("t3_q", b_q, quant(pr[31:16]));
            end
            tick();
        end
        check("t3_end_wr", 32'(b_wr), 32'd0);
        check("t3_cnt", b_cnt, 32'd8);

        // T4 backpressure, then swap toggled mid-word.
        push_b(64'h0004_0003_0002_0001);
        push_b(64'h0001_0002_0003_FFFF);
        #1;
        check("t4_pop", 32'(b_rd), 32'd1);
        tick();
        check("t4_p0_wr", 32'(b_wr), 32'd1);
        check("t4_p0_i", b_i, 32'h00000400);
        check("t4_p0_q", b_q, 32'h00000800);
        check("t4_p0_rd", 32'(b_rd), 32'd0);
        tick();
        b_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_full_wr", 32'(b_wr), 32'd0);
            check("t4_full_rd", 32'(b_rd), 32'd0);
            check("t4_full_i", b_i, 32'h00000C00);
            check("t4_full_q", b_q, 32'h00001000);
            tick();
        end
        b_full = 1'b0;
        #1;
        check("t4_rel_wr", 32'(b_wr), 32'd1);
        check("t4_rel_rd", 32'(b_rd), 32'd1);
        check("t4_rel_i", b_i, 32'h00000C00);
        tick();
        b_swap = 1'b1;
        #1;
        check("t2_a0_i", b_i, 32'hFFFFFC00);
        check("t2_a0_q", b_q, 32'h00000C00);
        tick();
        push_b(64'h0001_0002_0003_FFFF);
        #1;
        check("t2_a1_i", b_i, 32'h00000800);
        check("t2_a1_q", b_q, 32'h00000400);
        check("t2_a1_rd", 32'(b_rd), 32'd1);
        tick();
        check("t2_b0_i", b_i, 32'h00000C00);
        check("t2_b0_q", b_q, 32'hFFFFFC00);
        tick();
        check("t2_b1_i", b_i, 32'h00000400);
        check("t2_b1_q", b_q, 32'h00000800);
        check("t2_b1_rd", 32'(b_rd), 32'd0);
        tick();
        check("t4_idle_wr", 32'(b_wr), 32'd0);
        check("t4_cnt", b_cnt, 32'd14);

        // T5: flush against a pending write and a pending pop.
        b_swap = 1'b0;
        push_b(64'h0004_0003_0002_0001);
        #1;
        check("t5_pop", 32'(b_rd), 32'd1);
        tick();
        check("t5_p0_wr", 32'(b_wr), 32'd1);
        tick();
        push_b(64'h0001_0002_0003_FFFF);
        b_flush = 1'b1;
        #1;
        check("t5_flush_wr", 32'(b_wr), 32'd0);
        check("t5_flush_rd", 32'(b_rd), 32'd0);
        tick();
        b_flush = 1'b0;
        #1;
        check("t5_empty_i", b_i, 32'd0);
        check("t5_cnt", b_cnt, 32'd15);
        check("t5_repop", 32'(b_rd), 32'd1);
        tick();
        check("t5_n0_wr", 32'(b_wr), 32'd1);
        check("t5_n0_i", b_i, 32'hFFFFFC00);
        check("t5_n0_q", b_q, 32'h00000C00);
        tick();
        check("t5_n1_i", b_i, 32'h00000800);
        check("t5_n1_q", b_q, 32'h00000400);
        tick();
        check("t5_end_wr", 32'(b_wr), 32'd0);
        check("t5_end_cnt", b_cnt, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
